// File: rtl/riscv_core_pkg.sv
// Shared core types and constants used by the fetch front end.
package riscv_core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: instruction-memory port, redirect input and decode handshake.
interface fetch_unit_if;
  import riscv_core_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [XLEN-1:0] out_instr;
  logic            fetch_fault;

  modport master (
    output imem_addr, out_valid, out_pc, out_pc_plus4, out_instr, fetch_fault,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_pc_plus4, out_instr, fetch_fault,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instr} entries; flush empties it in one cycle.
module fetch_queue
  import riscv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  fetch_entry_t  mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, redirect/fault FSM and decode handshake.
module fetch_unit
  import riscv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            push, pop, q_full, q_empty, out_valid;
  fetch_entry_t    head, tail_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Redirect wins over everything; a misaligned target is still latched so it can be inspected.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      state_d    = (bus.redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
    end else if (state_q == RUN && (!q_full || pop)) begin
      push       = 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  assign out_valid        = !q_empty && !bus.redirect_valid && (state_q == RUN);
  assign pop              = out_valid && bus.out_ready;
  assign tail_entry.pc    = fetch_pc_q;
  assign tail_entry.instr = bus.imem_data;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (tail_entry),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head)
  );

  assign bus.imem_addr    = fetch_pc_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_pc       = head.pc;
  assign bus.out_pc_plus4 = head.pc + 32'd4;
  assign bus.out_instr    = head.instr;
  assign bus.fetch_fault  = (state_q == FAULT);
endmodule
